// File: rtl/seg8_4_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: digit count,
// segment bit positions and the hex-to-segment table (active-high gfedcba).
package seg8_4_pkg;

   localparam int DIGITS = 4;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry n is the gfedcba pattern for hex digit n (index 15 listed first).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg8_4_scan_if.sv
// Display bus between the value source and the scan driver: value and dots in,
// digit enables and segment lines out.
interface seg8_4_scan_if;
   import seg8_4_pkg::*;

   logic [4*DIGITS-1:0] number;
   logic [DIGITS-1:0]   dot;
   logic [DIGITS-1:0]   sel;
   logic [7:0]          seg;

   modport master (output number, output dot, input sel, input seg);
   modport slave  (input number, input dot, output sel, output seg);

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to 7-segment decoder, active-high, bit order gfedcba.
module seg_hex_decode
   import seg8_4_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg7
);

   logic [6:0] pat;

   assign pat = HEX_SEG[nibble];

   always_comb begin
      seg7        = '0;
      seg7[SEG_A] = pat[0];
      seg7[SEG_B] = pat[1];
      seg7[SEG_C] = pat[2];
      seg7[SEG_D] = pat[3];
      seg7[SEG_E] = pat[4];
      seg7[SEG_F] = pat[5];
      seg7[SEG_G] = pat[6];
   end

endmodule

// File: rtl/seg8_4_scan.sv
// Time-multiplexed 4-digit hex display driver with per-digit dots.
// Define SEG8_4_BLANK_EN to blank leading zeros on digits 3..1.
module seg8_4_scan
   import seg8_4_pkg::*;
#(
   parameter int SCAN_DIV_W     = 15,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   seg8_4_scan_if.slave  bus
);

   // Inactive output levels double as the polarity XOR masks.
   localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [SCAN_DIV_W-1:0] PRESC_ONE = 1;

   logic [SCAN_DIV_W-1:0] prescaler;
   logic                  tick;
   logic [1:0]            idx;
   logic [1:0]            idx_next;
   logic [3:0]            nibble;
   logic [6:0]            hex_seg;
   logic [DIGITS-1:0]     blank;
   logic [DIGITS-1:0]     sel_on;
   logic [7:0]            seg_on;
   logic [DIGITS-1:0]     sel_q;
   logic [7:0]            seg_q;

   assign tick     = &prescaler;
   assign idx_next = idx + 2'd1;
   assign nibble   = bus.number[{idx_next, 2'b00} +: 4];

   seg_hex_decode u_hex_decode (
      .nibble (nibble),
      .seg7   (hex_seg)
   );

`ifdef SEG8_4_BLANK_EN
   // A digit is blank only while it and every more-significant nibble are zero.
   always_comb begin
      blank    = '0;
      blank[3] = (bus.number[15:12] == 4'h0);
      blank[2] = blank[3] & (bus.number[11:8] == 4'h0);
      blank[1] = blank[2] & (bus.number[7:4] == 4'h0);
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      sel_on                = 4'b0001 << idx_next;
      seg_on                = '0;
      seg_on[SEG_G:SEG_A]   = blank[idx_next] ? 7'h00 : hex_seg;
      seg_on[SEG_DP]        = bus.dot[idx_next];
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         idx       <= 2'd3;
         sel_q     <= SEL_OFF;
         seg_q     <= SEG_OFF;
      end else begin
         prescaler <= prescaler + PRESC_ONE;
         if (tick) begin
            idx   <= idx_next;
            sel_q <= sel_on ^ SEL_OFF;
            seg_q <= seg_on ^ SEG_OFF;
         end
      end
   end

   assign bus.sel = sel_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg8_4_scan.sv
// Directed bench for seg8_4_scan with a 4-cycle scan period, active-low outputs.
module tb_seg8_4_scan;

   localparam int W = 2;
   localparam int P = 1 << W;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;

   always #10 clk_50m = ~clk_50m;

   seg8_4_scan_if bus ();

   seg8_4_scan #(
      .SCAN_DIV_W     (W),
      .SEL_ACTIVE_LOW (1),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int         checks = 0;
   int         passed = 0;
   logic [3:0] hold_sel = 4'hF;
   logic [7:0] hold_seg = 8'hFF;

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance n clocks from a negedge; outputs must hold until the last one.
   task automatic step(input int n, input logic [3:0] exp_sel, input logic [7:0] exp_seg,
                       input string tag, input bit scanning);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_50m);
         @(negedge clk_50m);
         if (i < n - 1) begin
            chk4({tag, "_hold_sel"}, bus.sel, hold_sel);
            chk8({tag, "_hold_seg"}, bus.seg, hold_seg);
         end else begin
            chk4({tag, "_sel"}, bus.sel, exp_sel);
            chk8({tag, "_seg"}, bus.seg, exp_seg);
            hold_sel = exp_sel;
            hold_seg = exp_seg;
         end
         if (scanning)
            chk_int({tag, "_onehot"}, $countones(~bus.sel), 1);
      end
   endtask

   initial begin
      bus.number = 16'h1234;
      bus.dot    = 4'b0000;
      repeat (2) @(negedge clk_50m);
      chk4("reset_sel", bus.sel, 4'hF);
      chk8("reset_seg", bus.seg, 8'hFF);

      rst_n = 1'b1;
      step(P, 4'b1110, 8'h99, "first_tick", 1'b0);
      step(P, 4'b1101, 8'hB0, "n1234_d1", 1'b1);
      step(P, 4'b1011, 8'hA4, "n1234_d2", 1'b1);
      step(P, 4'b0111, 8'hF9, "n1234_d3", 1'b1);
      step(P, 4'b1110, 8'h99, "n1234_d0", 1'b1);

      bus.number = 16'hAF08;
      bus.dot    = 4'b0001;
      step(P, 4'b1101, 8'hC0, "nAF08_d1", 1'b1);
      step(P, 4'b1011, 8'h8E, "nAF08_d2", 1'b1);
      step(P, 4'b0111, 8'h88, "nAF08_d3", 1'b1);
      step(P, 4'b1110, 8'h00, "nAF08_d0", 1'b1);

      bus.number = 16'h0000;
      bus.dot    = 4'b0000;
      step(P, 4'b1101, 8'hC0, "n0000_d1", 1'b1);
      step(P, 4'b1011, 8'hC0, "n0000_d2", 1'b1);
      step(2, 4'b1011, 8'hC0, "midframe_pre", 1'b1);
      bus.number = 16'hFFFF;
      step(1, 4'b1011, 8'hC0, "midframe_hold", 1'b1);
      step(1, 4'b0111, 8'h8E, "nFFFF_d3", 1'b1);
      step(P, 4'b1110, 8'h8E, "nFFFF_d0", 1'b1);
      step(P, 4'b1101, 8'h8E, "nFFFF_d1", 1'b1);
      step(P, 4'b1011, 8'h8E, "nFFFF_d2", 1'b1);

      // idx is 2 here; reset must act before the next clock edge.
      rst_n = 1'b0;
      #1;
      chk4("async_rst_sel", bus.sel, 4'hF);
      chk8("async_rst_seg", bus.seg, 8'hFF);
      hold_sel = 4'hF;
      hold_seg = 8'hFF;
      bus.number = 16'h0050;
      @(negedge clk_50m);
      @(negedge clk_50m);
      chk4("in_rst_sel", bus.sel, 4'hF);
      chk8("in_rst_seg", bus.seg, 8'hFF);
      rst_n = 1'b1;
      step(P, 4'b1110, 8'hC0, "restart_d0", 1'b0);
      step(P, 4'b1101, 8'h92, "n0050_d1", 1'b1);
`ifdef SEG8_4_BLANK_EN
      step(P, 4'b1011, 8'hFF, "blank_d2", 1'b1);
      step(P, 4'b0111, 8'hFF, "blank_d3", 1'b1);
`else
      step(P, 4'b1011, 8'hC0, "noblank_d2", 1'b1);
      step(P, 4'b0111, 8'hC0, "noblank_d3", 1'b1);
`endif
      step(P, 4'b1110, 8'hC0, "n0050_d0", 1'b1);

      bus.dot = 4'b1000;
`ifdef SEG8_4_BLANK_EN
      step(P, 4'b1101, 8'h92, "dotblank_d1", 1'b1);
      step(P, 4'b1011, 8'hFF, "dotblank_d2", 1'b1);
      step(P, 4'b0111, 8'h7F, "dotblank_d3", 1'b1);
`else
      step(P, 4'b1101, 8'h92, "dot_d1", 1'b1);
      step(P, 4'b1011, 8'hC0, "dot_d2", 1'b1);
      step(P, 4'b0111, 8'h40, "dot_d3", 1'b1);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
